// File: rtl/lfsr_pkg.sv
// Shared constants and state encoding for the LFSR stream checker.
// Expected per-period counts are derived from the LFSR width.
package lfsr_pkg;

  localparam int unsigned LFSR_N = 13;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned RUN_W  = 8;

  function automatic int unsigned exp_period(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic int unsigned exp_ones(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic int unsigned exp_zeros(input int unsigned n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  localparam int unsigned EXP_PERIOD = exp_period(LFSR_N);
  localparam int unsigned EXP_ONES   = exp_ones(LFSR_N);
  localparam int unsigned EXP_ZEROS  = exp_zeros(LFSR_N);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

endpackage

// File: rtl/run_length_tracker.sv
// Tracks runs of equal bits within a period: run count and longest 1/0 runs.
// Count/longest outputs are the values including the current sample (for latching on close).
module run_length_tracker
  import lfsr_pkg::*;
#(
  parameter int unsigned CW = CNT_W,
  parameter int unsigned RW = RUN_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_in,
  input  logic          sample,
  input  logic          start,
  input  logic          close,
  output logic [RW-1:0] cur_len,
  output logic [CW-1:0] run_cnt,
  output logic [RW-1:0] longest_one_run,
  output logic [RW-1:0] longest_zero_run
);

  logic          cur_val_q, cur_val_d;
  logic [RW-1:0] cur_len_q, cur_len_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [RW-1:0] lo_q, lo_d;
  logic [RW-1:0] lz_q, lz_d;

  function automatic logic [RW-1:0] inc_len(input logic [RW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] inc_cnt(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [RW-1:0] max_len(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    cur_val_d = cur_val_q;
    cur_len_d = cur_len_q;
    run_cnt_d = run_cnt_q;
    lo_d      = lo_q;
    lz_d      = lz_q;
    if (sample) begin
      if (start || (bit_in != cur_val_q)) begin
        if (!start) begin
          run_cnt_d = inc_cnt(run_cnt_q);
          if (cur_val_q) lo_d = max_len(lo_q, cur_len_q);
          else           lz_d = max_len(lz_q, cur_len_q);
        end
        cur_val_d = bit_in;
        cur_len_d = RW'(1);
      end else begin
        cur_len_d = inc_len(cur_len_q);
      end
      // Closing sample finishes the run it belongs to, even a freshly opened one.
      if (close) begin
        run_cnt_d = inc_cnt(run_cnt_d);
        if (cur_val_d) lo_d = max_len(lo_d, cur_len_d);
        else           lz_d = max_len(lz_d, cur_len_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_val_q <= 1'b0;
      cur_len_q <= '0;
      run_cnt_q <= '0;
      lo_q      <= '0;
      lz_q      <= '0;
    end else if (sample && close) begin
      cur_val_q <= 1'b0;
      cur_len_q <= '0;
      run_cnt_q <= '0;
      lo_q      <= '0;
      lz_q      <= '0;
    end else begin
      cur_val_q <= cur_val_d;
      cur_len_q <= cur_len_d;
      run_cnt_q <= run_cnt_d;
      lo_q      <= lo_d;
      lz_q      <= lz_d;
    end
  end

  // cur_len is the open run length before this cycle's sample; zero means no run open yet.
  assign cur_len          = cur_len_q;
  assign run_cnt          = run_cnt_d;
  assign longest_one_run  = lo_d;
  assign longest_zero_run = lz_d;

endmodule

// File: rtl/lfsr_stream_checker.sv
// Measures each LFSR period between ticks and issues a one-cycle report
// with a maximal-length balance pass flag, or a timeout if no tick arrives.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned N  = LFSR_N,
  parameter int unsigned CW = CNT_W,
  parameter int unsigned RW = RUN_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          period_tick,
  output logic [CW-1:0] ones_cnt,
  output logic [CW-1:0] zeros_cnt,
  output logic [CW-1:0] period_len,
  output logic [CW-1:0] run_cnt,
  output logic [RW-1:0] longest_one_run,
  output logic [RW-1:0] longest_zero_run,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic          locked
);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] EXP_PER_C  = CW'(exp_period(N));
  localparam logic [CW-1:0] EXP_ONES_C = CW'(exp_ones(N));
  localparam logic [CW-1:0] EXP_ZER_C  = CW'(exp_zeros(N));

  state_e        state_q, state_d;
  logic [CW-1:0] ones_q, ones_d, zeros_q, zeros_d, period_q, period_d;
  logic [CW-1:0] ones_cnt_q, ones_cnt_d, zeros_cnt_q, zeros_cnt_d;
  logic [CW-1:0] period_len_q, period_len_d, run_cnt_q, run_cnt_d;
  logic [RW-1:0] lo_run_q, lo_run_d, lz_run_q, lz_run_d;
  logic          done_q, done_d, pass_q, pass_d;
  logic          timeout_q, timeout_d, locked_q, locked_d;

  logic [CW-1:0] ones_nx, zeros_nx, period_nx;
  logic          collect_sample, period_end, timeout_hit, report, any_sat;
  logic [RW-1:0] trk_cur_len, trk_lo, trk_lz;
  logic [CW-1:0] trk_run_cnt;

  function automatic logic [CW-1:0] inc_cnt(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign collect_sample = (state_q == COLLECT) && bit_valid;
  assign ones_nx        = bit_in ? inc_cnt(ones_q) : ones_q;
  assign zeros_nx       = bit_in ? zeros_q : inc_cnt(zeros_q);
  assign period_nx      = inc_cnt(period_q);
  assign period_end     = collect_sample && period_tick;
  assign timeout_hit    = collect_sample && !period_tick && (period_nx == CNT_MAX);
  assign report         = period_end || timeout_hit;
  assign any_sat        = (ones_nx == CNT_MAX) || (zeros_nx == CNT_MAX) || (period_nx == CNT_MAX);

  run_length_tracker #(
    .CW (CW),
    .RW (RW)
  ) u_runs (
    .clk              (clk),
    .reset            (reset),
    .bit_in           (bit_in),
    .sample           (collect_sample),
    .start            (trk_cur_len == '0),
    .close            (report),
    .cur_len          (trk_cur_len),
    .run_cnt          (trk_run_cnt),
    .longest_one_run  (trk_lo),
    .longest_zero_run (trk_lz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bit_valid && period_tick) state_d = COLLECT;
      COLLECT: if (timeout_hit)              state_d = IDLE;
    endcase
  end

  always_comb begin
    ones_d       = ones_q;
    zeros_d      = zeros_q;
    period_d     = period_q;
    ones_cnt_d   = ones_cnt_q;
    zeros_cnt_d  = zeros_cnt_q;
    period_len_d = period_len_q;
    run_cnt_d    = run_cnt_q;
    lo_run_d     = lo_run_q;
    lz_run_d     = lz_run_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    locked_d     = locked_q;
    case (state_q)
      IDLE: begin
        if (bit_valid && period_tick) begin
          locked_d = 1'b1;
          ones_d   = '0;
          zeros_d  = '0;
          period_d = '0;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          if (report) begin
            ones_cnt_d   = ones_nx;
            zeros_cnt_d  = zeros_nx;
            period_len_d = period_nx;
            run_cnt_d    = trk_run_cnt;
            lo_run_d     = trk_lo;
            lz_run_d     = trk_lz;
            done_d       = 1'b1;
            timeout_d    = timeout_hit;
            pass_d       = period_end && !any_sat && (period_nx == EXP_PER_C) &&
                           (ones_nx == EXP_ONES_C) && (zeros_nx == EXP_ZER_C);
            if (timeout_hit) locked_d = 1'b0;
            ones_d   = '0;
            zeros_d  = '0;
            period_d = '0;
          end else begin
            ones_d   = ones_nx;
            zeros_d  = zeros_nx;
            period_d = period_nx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q       <= '0;
      zeros_q      <= '0;
      period_q     <= '0;
      ones_cnt_q   <= '0;
      zeros_cnt_q  <= '0;
      period_len_q <= '0;
      run_cnt_q    <= '0;
      lo_run_q     <= '0;
      lz_run_q     <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      ones_q       <= ones_d;
      zeros_q      <= zeros_d;
      period_q     <= period_d;
      ones_cnt_q   <= ones_cnt_d;
      zeros_cnt_q  <= zeros_cnt_d;
      period_len_q <= period_len_d;
      run_cnt_q    <= run_cnt_d;
      lo_run_q     <= lo_run_d;
      lz_run_q     <= lz_run_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      locked_q     <= locked_d;
    end
  end

  assign ones_cnt         = ones_cnt_q;
  assign zeros_cnt        = zeros_cnt_q;
  assign period_len       = period_len_q;
  assign run_cnt          = run_cnt_q;
  assign longest_one_run  = lo_run_q;
  assign longest_zero_run = lz_run_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign timeout          = timeout_q;
  assign locked           = locked_q;

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Downstream consumer of the 13-bit LFSR stage.
- Takes the serial output bit and the end-of-period tick, and measures each full period: ones, zeros, period length, run statistics.
- Issues a one-cycle report with a pass flag for maximal-length balance.
- Feeds the status/LED/UART reporting logic; replaces ad-hoc ones/zeros counting in the generator.

Parameters:
- N, 13, LFSR width; expected period 2^N-1, expected ones 2^(N-1), expected zeros 2^(N-1)-1.
- CW, 16, width of ones/zeros/period/run counters; all saturate at 2^CW-1.
- RW, 8, width of longest-run registers; saturate at 2^RW-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial LFSR bit.
- bit_valid  in  1  bit_in is a new sample this cycle.
- period_tick  in  1  marks the last sample of a period; effective only when bit_valid=1.
- ones_cnt  out  CW  ones in last completed period.
- zeros_cnt  out  CW  zeros in last completed period.
- period_len  out  CW  samples in last completed period.
- run_cnt  out  CW  number of runs in last completed period.
- longest_one_run  out  RW  longest run of 1s in last period.
- longest_zero_run  out  RW  longest run of 0s in last period.
- done  out  1  one-cycle pulse: report outputs updated.
- pass  out  1  last report met all balance checks.
- timeout  out  1  last report was a timeout (no tick within 2^CW-1 samples).
- locked  out  1  checker synchronised to period boundaries.

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0, all internal counters are 0, state is IDLE.
  - Reset release is effective on the next clk edge.
- Sample: a cycle with bit_valid=1. Cycles with bit_valid=0 change nothing; a period_tick in such a cycle is ignored.
- IDLE:
  - locked=0; samples are discarded.
  - On the first sample with period_tick=1: go to COLLECT, clear accumulators, set locked=1. That tick sample is not counted.
- COLLECT, per sample:
  - period++; ones++ if bit_in=1, else zeros++.
  - Run tracking: if bit_in equals the current run value, cur_len++. Otherwise close the run: run_cnt++, update longest for that value, start a new run with cur_len=1.
  - The first sample of a period always starts a new run.
- Period end (sample with period_tick=1 in COLLECT):
  - The sample is included in all counts, and the open run is closed with it included.
  - On the same clk edge: all report outputs latch the final values, done=1 for exactly one cycle, and accumulators clear for the next period. Report latency is 1 cycle after the tick sample.
  - A tick sample that also starts a new run closes that new run with length 1.
  - Next cycle's sample is the first sample of the new period; no dead cycle.
- pass=1 only if all of:
  - period_len=2^N-1
  - ones_cnt=2^(N-1)
  - zeros_cnt=2^(N-1)-1
  - no counter saturated.
- Runs do not affect pass; a run straddling the period boundary is split.
- Timeout: in COLLECT, if the period counter reaches 2^CW-1 without a tick:
  - Latch the report (counts saturated), done=1, pass=0, timeout=1, locked=0.
  - Go to IDLE.
  - timeout clears on the next normal report.
- Saturation: a counter at max holds its value, with no wrap. Run lengths saturate at 2^RW-1.
- Report outputs hold until the next done. done and the next-period accumulation never conflict.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_N=13
  - CNT_W=16
  - expected-count constants derived from N
  - the state enum {IDLE, COLLECT}
- One sub-module, run_length_tracker: bit_in, sample, start, close → cur_len, run_cnt, longest_one_run, longest_zero_run, with saturation.
- Top holds the FSM, ones/zeros/period counters and report latches.

Test Plan:
1. Real LFSR_13 stream, continuous valid; tick at the all-ones state. After the second tick: period_len=8191, ones_cnt=4096, zeros_cnt=4095, pass=1, done exactly one cycle, locked=1.
2. Stream 0,1,0,1… with a tick every 8th sample, after lock: ones=4, zeros=4, period=8, run_cnt=8, longest runs 1/1, pass=0.
3. Stream 1,1,1,0,0 repeating (period 5), with bit_valid low every other cycle and a tick pulsed in an invalid cycle. Invalid-cycle tick ignored; on the valid tick: period=5, ones=3, zeros=2, longest_one_run=3, longest_zero_run=2.
4. Ticks before lock: first tick sample not counted; no done on the first tick; done one cycle after the second tick.
5. Reset asserted mid-period (after 100 samples). All outputs 0 immediately, asynchronously; after release, IDLE until the next tick.
6. Lock, then 65535 samples with no tick: done=1, timeout=1, pass=0, period_len=65535, locked=0; the next two ticks give a normal report with timeout=0.
